// File: rtl/efa_pkg.sv
// rtl/efa_pkg.sv - shared constants and types for the EFA lookup scheduler.
package efa_pkg;
   localparam int NUM_REQ      = 4;
   localparam int T_FIX_WID    = 16;
   localparam int EFA_LAT      = 4;
   localparam int ID_WID       = $clog2(NUM_REQ);
   localparam int RAM_SEL_SCAL = 4;
   localparam int RAM_SEL_TEMP = 5;

   typedef enum logic [1:0] {RUN, DRAIN, CFG} efa_sched_st_t;

   typedef struct packed {
      logic              v;
      logic [ID_WID-1:0] id;
   } efa_tag_t;
endpackage

// File: rtl/efa_sched_if.sv
// rtl/efa_sched_if.sv - requester, EFA and host-config signals of the scheduler.
interface efa_sched_if;
   import efa_pkg::*;

   logic [NUM_REQ-1:0]           req;
   logic [NUM_REQ*T_FIX_WID-1:0] req_t_fix;
   logic [NUM_REQ-1:0]           gnt;
   logic                         efa_re;
   logic [T_FIX_WID-1:0]         efa_t_fix;
   logic [T_FIX_WID-1:0]         efa_out;
   logic                         rsp_valid;
   logic [ID_WID-1:0]            rsp_id;
   logic [T_FIX_WID-1:0]         rsp_val;
   logic                         cfg_req;
   logic                         cfg_gnt;
   logic                         busy;

   modport master (
      output req, req_t_fix, efa_out, cfg_req,
      input  gnt, efa_re, efa_t_fix, rsp_valid, rsp_id, rsp_val, cfg_gnt, busy
   );

   modport slave (
      input  req, req_t_fix, efa_out, cfg_req,
      output gnt, efa_re, efa_t_fix, rsp_valid, rsp_id, rsp_val, cfg_gnt, busy
   );
endinterface

// File: rtl/efa_sched_rr_arbiter.sv
// rtl/efa_sched_rr_arbiter.sv - round-robin arbiter: first request at or after ptr wins.
module rr_arbiter #(
   parameter int N = 4,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [N-1:0] gnt,
   output logic [W-1:0] winner,
   output logic         found
);
   always_comb begin : search
      int idx;
      idx    = 0;
      gnt    = '0;
      winner = '0;
      found  = 1'b0;
      for (int k = 0; k < N; k++) begin
         idx = (int'(ptr) + k) % N;
         if (!found && req[idx]) begin
            found    = 1'b1;
            gnt[idx] = 1'b1;
            winner   = W'(idx);
         end
      end
   end
endmodule

// File: rtl/efa_sched.sv
// rtl/efa_sched.sv - shares one EFA pipeline among requesters, tags results with
// requester IDs and quiesces lookups around host LUT rewrites.
module efa_sched
   import efa_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   efa_sched_if.slave  bus
);
   efa_sched_st_t      state;
   logic [ID_WID-1:0]  ptr;
   logic [ID_WID-1:0]  winner;
   logic [ID_WID-1:0]  next_ptr;
   logic [NUM_REQ-1:0] arb_req;
   logic [NUM_REQ-1:0] arb_gnt;
   logic               found;
   logic               cfg_gnt_q;
   logic               drain_done;
   logic               any_valid;
   efa_tag_t           tags [EFA_LAT];

   // A pending cfg_req blocks arbitration in the same cycle it is seen.
   assign arb_req = (state == RUN && !bus.cfg_req) ? bus.req : '0;

   rr_arbiter #(.N(NUM_REQ), .W(ID_WID)) u_arb (
      .req    (arb_req),
      .ptr    (ptr),
      .gnt    (arb_gnt),
      .winner (winner),
      .found  (found)
   );

   assign next_ptr      = (winner == ID_WID'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
   assign bus.gnt       = arb_gnt;
   assign bus.efa_re    = found;
   assign bus.efa_t_fix = found ? bus.req_t_fix[int'(winner)*T_FIX_WID +: T_FIX_WID] : '0;

   assign bus.rsp_valid = tags[EFA_LAT-1].v;
   assign bus.rsp_id    = tags[EFA_LAT-1].v ? tags[EFA_LAT-1].id : '0;
   assign bus.rsp_val   = tags[EFA_LAT-1].v ? bus.efa_out : '0;
   assign bus.cfg_gnt   = cfg_gnt_q;
   assign bus.busy      = any_valid;

   // The last stage completes this cycle, so only earlier stages hold up the drain.
   always_comb begin
      drain_done = 1'b1;
      any_valid  = tags[EFA_LAT-1].v;
      for (int k = 0; k < EFA_LAT - 1; k++) begin
         if (tags[k].v) begin
            drain_done = 1'b0;
            any_valid  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= RUN;
         ptr       <= '0;
         cfg_gnt_q <= 1'b0;
         for (int k = 0; k < EFA_LAT; k++) tags[k] <= '0;
      end else begin
         tags[0].v  <= found;
         tags[0].id <= winner;
         for (int k = 1; k < EFA_LAT; k++) tags[k] <= tags[k-1];
         if (found) ptr <= next_ptr;
         case (state)
            RUN: begin
               if (bus.cfg_req) state <= DRAIN;
            end
            DRAIN: begin
               if (!bus.cfg_req) begin
                  state <= RUN;
               end else if (drain_done) begin
                  state     <= CFG;
                  cfg_gnt_q <= 1'b1;
               end
            end
            CFG: begin
               if (!bus.cfg_req) begin
                  state     <= RUN;
                  cfg_gnt_q <= 1'b0;
               end
            end
            default: state <= RUN;
         endcase
      end
   end
endmodule
